alt_ddrx_bank_cmd_sched: RTL
============================

ALT_DDRX_BANK_CMD_SCHED -- requirements
Module: alt_ddrx_bank_cmd_sched

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 8, number of bank timer instances driven.
REQ-002 SHALL have parameter BANK_ADDR_WIDTH, default 3, width of bank index.
REQ-003 SHALL have parameter MEM_IF_ROW_WIDTH, default 16, row address width.
REQ-004 SHALL have port ctl_clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port ctl_reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted when req_valid & req_ready.
REQ-008 SHALL have port req_bank  input  BANK_ADDR_WIDTH  target bank.
REQ-009 SHALL have port req_row  input  MEM_IF_ROW_WIDTH  target row.
REQ-010 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-011 SHALL have port bank_state  input  NUM_BANKS  per-bank open (1) / idle (0).
REQ-012 SHALL have port bank_row  input  NUM_BANKS*MEM_IF_ROW_WIDTH  per-bank open row, bank i at slice i.
REQ-013 SHALL have ports bank_rdwr_ready, bank_act_ready, bank_pch_ready  input  NUM_BANKS each  per-bank timing readiness.
REQ-014 SHALL have ports cmd_open, cmd_close, cmd_read, cmd_write  output  NUM_BANKS each  per-bank command strobes.
REQ-015 SHALL have port cmd_row_addr  output  MEM_IF_ROW_WIDTH  row for cmd_open.
REQ-016 SHALL have port busy  output  1  request held, not yet completed.

Function
REQ-017 SHALL implement FSM states IDLE, PCH, ACT, RDWR, SETTLE.
REQ-018 SHALL assert req_ready only in IDLE; acceptance latches bank, row, write flag.
REQ-019 SHALL, on acceptance with bank idle, go ACT; with bank open (open-page build only, row hit) go RDWR; row miss go PCH.
REQ-020 SHALL in PCH pulse cmd_close[bank] for one cycle when bank_pch_ready[bank]=1, then SETTLE -> ACT.
REQ-021 SHALL in ACT pulse cmd_open[bank] with cmd_row_addr=latched row when bank_act_ready[bank]=1, then SETTLE -> RDWR.
REQ-022 SHALL in RDWR pulse cmd_read or cmd_write[bank] when bank_rdwr_ready[bank]=1, then SETTLE -> IDLE.
REQ-023 SHALL spend exactly one SETTLE cycle after every command, ignoring all ready inputs, so registered bank-timer readiness reflects the command.
REQ-024 SHALL issue at most one strobe per cycle; all cmd_* vectors zero or one-hot on the latched bank.
REQ-025 SHALL wait indefinitely in PCH/ACT/RDWR while the required ready is 0; no timeout.
REQ-026 SHALL give minimum close-page latency: accept at T, cmd_open T+1, cmd_read/write T+3, req_ready again T+5.
REQ-027 SHALL drive busy=1 from cycle after acceptance until return to IDLE.
REQ-028 SHALL hold cmd_row_addr at latched row while not in IDLE.

Reset
REQ-029 SHALL on ctl_reset force IDLE, all cmd_* = 0, cmd_row_addr = 0, busy = 0, req_ready = 0 during reset, 1 first cycle after release.
REQ-030 SHALL on reset mid-operation drop the held request with no further strobes.

Configuration
REQ-031 SHALL, with ALT_DDRX_OPEN_PAGE_EN defined, use bank_state/bank_row for hit/miss (REQ-019) and issue RD/WR without cmd_close.
REQ-032 SHALL, without ALT_DDRX_OPEN_PAGE_EN, ignore bank_row, always go ACT on acceptance (waiting in ACT if bank busy) and assert cmd_close[bank] together with the RD/WR strobe (auto-precharge).

Structure
REQ-033 SHALL place FSM state enum and command-type constants in shared package alt_ddrx_sched_pkg.
REQ-034 SHALL contain one sub-module alt_ddrx_bank_sel: combinational mux of per-bank ready/state/row by latched bank index.

Verification
REQ-035 SHALL cover close-page read, bank 2 row 0x0123, all readies 1: cmd_open[2] at T+1 row 0x0123, cmd_read[2]&cmd_close[2] at T+3, req_ready T+5.
REQ-036 SHALL cover act stall: bank_act_ready[5]=0 for 10 cycles after write accepted: no strobe until ready, cmd_open[5] the cycle ready rises.
REQ-037 SHALL cover open-page row hit: bank 1 open row 0x0040, request row 0x0040 write: only cmd_write[1], at T+1.
REQ-038 SHALL cover open-page row miss: bank 1 open row 0x0040, request 0x0041: cmd_close[1] T+1, cmd_open[1] T+3 row 0x0041, cmd_read[1] T+5.
REQ-039 SHALL cover reset asserted in RDWR with bank_rdwr_ready=0: outputs zero immediately, no strobe after release, req_ready=1.
REQ-040 SHALL cover one-hot check: random 1000 requests, every cycle popcount of OR of cmd_* vectors <= 1.

Source files
------------

// File: rtl/alt_ddrx_sched_pkg.sv
// alt_ddrx_sched_pkg: shared FSM state and command-type encodings for the bank command scheduler.
package alt_ddrx_sched_pkg;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PCH    = 3'd1;
    localparam logic [2:0] ST_ACT    = 3'd2;
    localparam logic [2:0] ST_RDWR   = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_CLOSE = 3'd1;
    localparam logic [2:0] CMD_OPEN  = 3'd2;
    localparam logic [2:0] CMD_READ  = 3'd3;
    localparam logic [2:0] CMD_WRITE = 3'd4;

    // State to resume once the settle cycle that follows a command in state s is over.
    function automatic logic [2:0] next_after(input logic [2:0] s);
        return s == ST_PCH ? ST_ACT : s == ST_ACT ? ST_RDWR : ST_IDLE;
    endfunction
endpackage

// File: rtl/alt_ddrx_bank_cmd_sched_if.sv
// alt_ddrx_bank_cmd_sched_if: valid/ready request bus into the bank command scheduler.
interface alt_ddrx_bank_cmd_sched_if #(
    parameter int BANK_ADDR_WIDTH  = 3,
    parameter int MEM_IF_ROW_WIDTH = 16
);
    logic                        req_valid;
    logic                        req_ready;
    logic [BANK_ADDR_WIDTH-1:0]  req_bank;
    logic [MEM_IF_ROW_WIDTH-1:0] req_row;
    logic                        req_write;

    modport master (output req_valid, req_bank, req_row, req_write, input req_ready);
    modport slave  (input req_valid, req_bank, req_row, req_write, output req_ready);
endinterface

// File: rtl/alt_ddrx_bank_sel.sv
// alt_ddrx_bank_sel: selects one bank's readiness, open state and open row by bank index.
module alt_ddrx_bank_sel #(
    parameter int NUM_BANKS        = 8,
    parameter int BANK_ADDR_WIDTH  = 3,
    parameter int MEM_IF_ROW_WIDTH = 16
) (
    input  logic [BANK_ADDR_WIDTH-1:0]            idx,
    input  logic [NUM_BANKS-1:0]                  bank_state,
    input  logic [NUM_BANKS*MEM_IF_ROW_WIDTH-1:0] bank_row,
    input  logic [NUM_BANKS-1:0]                  bank_rdwr_ready,
    input  logic [NUM_BANKS-1:0]                  bank_act_ready,
    input  logic [NUM_BANKS-1:0]                  bank_pch_ready,
    output logic                                  sel_state,
    output logic [MEM_IF_ROW_WIDTH-1:0]           sel_row,
    output logic                                  sel_rdwr,
    output logic                                  sel_act,
    output logic                                  sel_pch
);
    always_comb begin
        sel_state = bank_state[idx];
        sel_row   = bank_row[int'(idx)*MEM_IF_ROW_WIDTH +: MEM_IF_ROW_WIDTH];
        sel_rdwr  = bank_rdwr_ready[idx];
        sel_act   = bank_act_ready[idx];
        sel_pch   = bank_pch_ready[idx];
    end
endmodule

// File: rtl/alt_ddrx_bank_cmd_sched.sv
// alt_ddrx_bank_cmd_sched: one-request-at-a-time PCH/ACT/RDWR sequencer with a settle cycle after each command.
// ALT_DDRX_OPEN_PAGE_EN selects open-page hit/miss handling; otherwise close-page with auto-precharge.
module alt_ddrx_bank_cmd_sched
    import alt_ddrx_sched_pkg::*;
#(
    parameter int NUM_BANKS        = 8,
    parameter int BANK_ADDR_WIDTH  = 3,
    parameter int MEM_IF_ROW_WIDTH = 16
) (
    input  logic                                  ctl_clk,
    input  logic                                  ctl_reset,
    alt_ddrx_bank_cmd_sched_if.slave              req,
    input  logic [NUM_BANKS-1:0]                  bank_state,
    input  logic [NUM_BANKS*MEM_IF_ROW_WIDTH-1:0] bank_row,
    input  logic [NUM_BANKS-1:0]                  bank_rdwr_ready,
    input  logic [NUM_BANKS-1:0]                  bank_act_ready,
    input  logic [NUM_BANKS-1:0]                  bank_pch_ready,
    output logic [NUM_BANKS-1:0]                  cmd_open,
    output logic [NUM_BANKS-1:0]                  cmd_close,
    output logic [NUM_BANKS-1:0]                  cmd_read,
    output logic [NUM_BANKS-1:0]                  cmd_write,
    output logic [MEM_IF_ROW_WIDTH-1:0]           cmd_row_addr,
    output logic                                  busy
);
    logic [2:0]                  state, after, first_state, cmd;
    logic [BANK_ADDR_WIDTH-1:0]  bank_q, sel_idx;
    logic [MEM_IF_ROW_WIDTH-1:0] row_q, sel_row;
    logic                        write_q, accept, sel_state, sel_rdwr, sel_act, sel_pch;
    logic [NUM_BANKS-1:0]        bank_oh;

    // While idle the selector looks at the incoming bank so hit/miss is known at acceptance.
    assign sel_idx = state == ST_IDLE ? req.req_bank : bank_q;

    alt_ddrx_bank_sel #(
        .NUM_BANKS(NUM_BANKS), .BANK_ADDR_WIDTH(BANK_ADDR_WIDTH), .MEM_IF_ROW_WIDTH(MEM_IF_ROW_WIDTH)
    ) u_sel (
        .idx(sel_idx), .bank_state(bank_state), .bank_row(bank_row),
        .bank_rdwr_ready(bank_rdwr_ready), .bank_act_ready(bank_act_ready), .bank_pch_ready(bank_pch_ready),
        .sel_state(sel_state), .sel_row(sel_row), .sel_rdwr(sel_rdwr), .sel_act(sel_act), .sel_pch(sel_pch)
    );

`ifdef ALT_DDRX_OPEN_PAGE_EN
    localparam bit AUTO_PCH = 1'b0;
    assign first_state = !sel_state ? ST_ACT : sel_row == req.req_row ? ST_RDWR : ST_PCH;
`else
    localparam bit AUTO_PCH = 1'b1;
    logic unused_open_page;
    assign unused_open_page = ^{sel_state, sel_row};
    assign first_state = ST_ACT;
`endif

    assign req.req_ready = state == ST_IDLE && !ctl_reset;
    assign accept        = req.req_valid && req.req_ready;
    assign busy          = state != ST_IDLE;
    assign cmd_row_addr  = row_q;
    assign bank_oh       = NUM_BANKS'(1) << bank_q;

    assign cmd = state == ST_PCH  && sel_pch  ? CMD_CLOSE :
                 state == ST_ACT  && sel_act  ? CMD_OPEN  :
                 state == ST_RDWR && sel_rdwr ? (write_q ? CMD_WRITE : CMD_READ) : CMD_NONE;

    assign cmd_open  = cmd == CMD_OPEN  ? bank_oh : '0;
    assign cmd_read  = cmd == CMD_READ  ? bank_oh : '0;
    assign cmd_write = cmd == CMD_WRITE ? bank_oh : '0;
    assign cmd_close = cmd == CMD_CLOSE || (AUTO_PCH && (cmd == CMD_READ || cmd == CMD_WRITE)) ? bank_oh : '0;

    always_ff @(posedge ctl_clk or posedge ctl_reset) begin
        if (ctl_reset) begin
            state   <= ST_IDLE;
            after   <= ST_IDLE;
            bank_q  <= '0;
            row_q   <= '0;
            write_q <= 1'b0;
        end else if (accept) begin
            state   <= first_state;
            bank_q  <= req.req_bank;
            row_q   <= req.req_row;
            write_q <= req.req_write;
        end else if (cmd != CMD_NONE) begin
            state <= ST_SETTLE;
            after <= next_after(state);
        end else if (state == ST_SETTLE) begin
            state <= after;
        end
    end
endmodule
